// File: rtl/mc14500b_sequencer.sv
// Program sequencer for an MC14500B ICU: FETCH, LATCH, EXEC x EXEC_CYCLES, UPDATE, so one
// instruction takes EXEC_CYCLES+3 cycles. run=0 stops at the next instruction boundary; flgf parks in HALT.
module mc14500b_sequencer #(
    parameter int AW          = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          run,
    output logic [AW-1:0] prog_addr,
    input  logic [AW+3:0] prog_data,
    output logic [3:0]    I,
    output logic [AW-1:0] io_addr,
    output logic          instr_valid,
    input  logic          jmp,
    input  logic          rtn,
    input  logic          flgf,
    output logic          halted,
    output logic          ret_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [3:0] LAST_EXEC = 4'(EXEC_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ret_addr;
    logic          r_ret_valid;
    logic [AW+3:0] r_ir;
    logic [3:0]    r_cnt;
    logic          r_jmp;
    logic          r_rtn;
    logic          r_flgf;
    logic          w_last_exec;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_operand;

    assign w_last_exec = (r_state == S_EXEC) && (r_cnt == LAST_EXEC);
    assign w_pc_inc    = r_pc + AW'(1);
    assign w_operand   = r_ir[AW-1:0];
    assign prog_addr   = r_pc;
    assign io_addr     = w_operand;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = S_EXEC;
            S_EXEC:   if (w_last_exec) w_next = S_UPDATE;
            S_UPDATE: begin
                if (r_flgf)   w_next = S_HALT;
                else if (run) w_next = S_FETCH;
                else          w_next = S_IDLE;
            end
            S_HALT:   if (!run) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Flags are captured only on the final EXEC cycle; UPDATE acts on the captured copy.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_pc        <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_ir        <= '0;
            r_cnt       <= '0;
            r_jmp       <= 1'b0;
            r_rtn       <= 1'b0;
            r_flgf      <= 1'b0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    r_ir  <= prog_data;
                    r_cnt <= '0;
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last_exec) begin
                        r_jmp  <= jmp;
                        r_rtn  <= rtn;
                        r_flgf <= flgf;
                    end
                end
                S_UPDATE: begin
                    if (r_flgf) begin
                        r_pc <= w_pc_inc;
                    end else if (r_jmp) begin
                        r_ret_addr  <= w_pc_inc;
                        r_ret_valid <= 1'b1;
                        r_pc        <= w_operand;
                    end else if (r_rtn && r_ret_valid) begin
                        r_pc        <= r_ret_addr;
                        r_ret_valid <= 1'b0;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        I           = 4'b0000;
        instr_valid = 1'b0;
        halted      = 1'b0;
        ret_err     = 1'b0;
        case (r_state)
            S_EXEC: begin
                I           = r_ir[AW+3:AW];
                instr_valid = 1'b1;
            end
            S_UPDATE: ret_err = r_rtn && !r_jmp && !r_flgf && !r_ret_valid;
            S_HALT:   halted  = 1'b1;
            default: ;
        endcase
    end

endmodule
